// File: rtl/regfile_dump.sv
// regfile_dump: streams register pairs 0..LAST_ADDR out of a two-port register file
// over a valid/ready interface, fetching each pair just before sending it.
module regfile_dump #(
   parameter int LAST_ADDR = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  rdAddrA,
   output logic [4:0]  rdAddrB,
   input  logic [63:0] rdDataA,
   input  logic [63:0] rdDataB,
   output logic [63:0] outData,
   output logic [4:0]  outAddr,
   output logic        outValid,
   input  logic        outReady,
   output logic        busy,
   output logic        done
);
   typedef enum logic [2:0] {IDLE, FETCH, SEND_A, SEND_B, DONE} state_t;
   localparam logic [4:0] LAST = 5'(LAST_ADDR);
   state_t      state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [63:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
   logic [4:0]  ptr_inc;
   assign ptr_inc = ptr_q + 5'd1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         buf_a_q <= '0;
         buf_b_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         buf_a_q <= buf_a_d;
         buf_b_q <= buf_b_d;
      end
   end
   // Outputs decode from state only, so an asynchronous reset clears them at once.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      buf_a_d  = buf_a_q;
      buf_b_d  = buf_b_q;
      rdAddrA  = '0;
      rdAddrB  = '0;
      outData  = '0;
      outAddr  = '0;
      outValid = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            busy    = 1'b1;
            rdAddrA = ptr_q;
            rdAddrB = ptr_inc;
            buf_a_d = rdDataA;
            buf_b_d = rdDataB;
            state_d = SEND_A;
         end
         SEND_A: begin
            busy     = 1'b1;
            outValid = 1'b1;
            outData  = buf_a_q;
            outAddr  = ptr_q;
            if (outReady) state_d = SEND_B;
         end
         SEND_B: begin
            busy     = 1'b1;
            outValid = 1'b1;
            outData  = buf_b_q;
            outAddr  = ptr_inc;
            if (outReady) begin
               if (ptr_inc == LAST) state_d = DONE;
               else begin
                  ptr_d   = ptr_q + 5'd2;
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: checks the register dump streamer against a word-sequence model of the
// register file, with fixed-timing vectors and randomized backpressure.
module tb_regfile_dump;
   logic clk = 0, reset = 0, start = 0, outReady = 0, sel = 0;
   always #5 clk = ~clk;
   logic [63:0] mem [32];
   logic [63:0] exp_mem [32];
   logic [4:0]  ra_a, rb_a, oa_a, ra_b, rb_b, oa_b;
   logic [63:0] od_a, od_b, rda_a, rdb_a, rda_b, rdb_b;
   logic        ov_a, bz_a, dn_a, ov_b, bz_b, dn_b;
   assign rda_a = mem[ra_a];
   assign rdb_a = mem[rb_a];
   assign rda_b = mem[ra_b];
   assign rdb_b = mem[rb_b];
   regfile_dump u_dut (
      .clk(clk), .reset(reset), .start(start & !sel),
      .rdAddrA(ra_a), .rdAddrB(rb_a), .rdDataA(rda_a), .rdDataB(rdb_a),
      .outData(od_a), .outAddr(oa_a), .outValid(ov_a), .outReady(outReady),
      .busy(bz_a), .done(dn_a)
   );
   regfile_dump #(.LAST_ADDR(7)) u_dut7 (
      .clk(clk), .reset(reset), .start(start & sel),
      .rdAddrA(ra_b), .rdAddrB(rb_b), .rdDataA(rda_b), .rdDataB(rdb_b),
      .outData(od_b), .outAddr(oa_b), .outValid(ov_b), .outReady(outReady),
      .busy(bz_b), .done(dn_b)
   );
   logic [4:0]  c_ra, c_rb, c_oa;
   logic [63:0] c_od;
   logic        c_ov, c_bz, c_dn;
   assign c_ra = sel ? ra_b : ra_a;
   assign c_rb = sel ? rb_b : rb_a;
   assign c_oa = sel ? oa_b : oa_a;
   assign c_od = sel ? od_b : od_a;
   assign c_ov = sel ? ov_b : ov_a;
   assign c_bz = sel ? bz_b : bz_a;
   assign c_dn = sel ? dn_b : dn_a;
   int vectors = 0, miscompares = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic preload();
      for (int i = 0; i < 32; i++) mem[i] = '0;
      mem[0]  = 64'hFFFFFFFFFFFFFFFF;
      mem[8]  = 64'hAAAAAAAAAAAAAAAA;
      mem[15] = 64'hCCCCCCCCCCCCCCCC;
      mem[31] = 64'hF0F0F0F0F0F0F0F0;
   endtask
   task automatic snap();
      for (int i = 0; i < 32; i++) exp_mem[i] = mem[i];
   endtask
   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask
   // Runs one dump and checks the transferred words against exp_mem; optional regfile write at cycle wr_cyc.
   task automatic run_dump(input string tag, input int last, input int duty, input int wr_cyc,
                           input logic [4:0] wr_a, input logic [63:0] wr_d, input int exp_busy);
      logic [4:0]  got_a [$];
      logic [63:0] got_d [$];
      logic        p_ov = 0, p_rdy = 0, fin = 0;
      logic [4:0]  p_oa = 0;
      logic [63:0] p_od = 0;
      int          busy_n = 0;
      outReady = 1;
      pulse_start();
      for (int c = 0; c < 2000 && !fin; c++) begin
         if (c == wr_cyc) mem[wr_a] = wr_d;
         outReady = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
         @(negedge clk);
         if (c_bz) busy_n++;
         if (p_ov && !p_rdy) begin
            chk({tag, " stall_valid"}, 128'(c_ov), 128'(1));
            chk({tag, " stall_word"}, {59'd0, c_oa, c_od}, {59'd0, p_oa, p_od});
         end
         if (c_ov && outReady) begin
            got_a.push_back(c_oa);
            got_d.push_back(c_od);
         end
         if (c_dn) fin = 1;
         p_ov = c_ov; p_rdy = outReady; p_oa = c_oa; p_od = c_od;
         @(posedge clk); #1;
      end
      chk({tag, " done_seen"}, 128'(fin), 128'(1));
      @(negedge clk);
      chk({tag, " post_done"}, {126'd0, c_dn, c_bz}, 128'd0);
      if (exp_busy >= 0) chk({tag, " busy_cycles"}, 128'(busy_n), 128'(exp_busy));
      chk({tag, " word_count"}, 128'(got_a.size()), 128'(last + 1));
      for (int i = 0; i < got_a.size(); i++) begin
         chk({tag, " addr"}, 128'(got_a[i]), 128'(i));
         chk({tag, " data"}, 128'(got_d[i]), (i < 32) ? 128'(exp_mem[i]) : 128'd0);
      end
   endtask
   typedef struct {
      int          cyc;
      logic        busy, valid, done;
      logic [4:0]  addr, rda, rdb;
      logic [63:0] data;
   } vec_t;
   vec_t vecs [12];
   initial begin
      vecs[0]  = '{0,  1, 0, 0, 5'd0,  5'd0,  5'd1,  64'h0};
      vecs[1]  = '{1,  1, 1, 0, 5'd0,  5'd0,  5'd0,  64'hFFFFFFFFFFFFFFFF};
      vecs[2]  = '{2,  1, 1, 0, 5'd1,  5'd0,  5'd0,  64'h0};
      vecs[3]  = '{3,  1, 0, 0, 5'd0,  5'd2,  5'd3,  64'h0};
      vecs[4]  = '{4,  1, 1, 0, 5'd2,  5'd0,  5'd0,  64'h0};
      vecs[5]  = '{25, 1, 1, 0, 5'd16, 5'd0,  5'd0,  64'h0};
      vecs[6]  = '{23, 1, 1, 0, 5'd15, 5'd0,  5'd0,  64'hCCCCCCCCCCCCCCCC};
      vecs[7]  = '{45, 1, 0, 0, 5'd0,  5'd30, 5'd31, 64'h0};
      vecs[8]  = '{47, 1, 1, 0, 5'd31, 5'd0,  5'd0,  64'hF0F0F0F0F0F0F0F0};
      vecs[9]  = '{48, 0, 0, 1, 5'd0,  5'd0,  5'd0,  64'h0};
      vecs[10] = '{49, 0, 0, 0, 5'd0,  5'd0,  5'd0,  64'h0};
      vecs[11] = '{13, 1, 1, 0, 5'd8,  5'd0,  5'd0,  64'hAAAAAAAAAAAAAAAA};
      preload();
      #3;
      chk("reset_outputs", {c_od, 27'd0, c_oa, c_ra, c_rb, c_ov, c_bz, c_dn}, 128'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 outReady = i[0];
         @(negedge clk);
         chk("idle_outputs", {c_od, 27'd0, c_oa, c_ra, c_rb, c_ov, c_bz, c_dn}, 128'd0);
      end
      // fixed-timing table, applied in cycle order
      outReady = 1;
      pulse_start();
      for (int c = 0; c <= 49; c++) begin
         @(negedge clk);
         for (int k = 0; k < 12; k++)
            if (vecs[k].cyc == c)
               chk($sformatf("vec_c%0d", c),
                   {46'd0, c_bz, c_ov, c_dn, c_oa, c_ra, c_rb, c_od},
                   {46'd0, vecs[k].busy, vecs[k].valid, vecs[k].done, vecs[k].addr, vecs[k].rda, vecs[k].rdb, vecs[k].data});
         @(posedge clk); #1;
      end
      snap();
      run_dump("full", 31, 100, -1, 5'd0, 64'd0, 48);
      run_dump("bp30", 31, 30, -1, 5'd0, 64'd0, -1);
      for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
      snap();
      run_dump("rand", 31, $urandom_range(20, 80), -1, 5'd0, 64'd0, -1);
      preload();
      snap();
      sel = 1;
      run_dump("last7", 7, 100, -1, 5'd0, 64'd0, 12);
      run_dump("last7bp", 7, 40, -1, 5'd0, 64'd0, -1);
      sel = 0;
      // regfile write just after / just before the pair 8/9 fetch
      snap();
      run_dump("wr_after", 31, 100, 13, 5'd9, 64'h0123456789ABCDEF, 48);
      mem[9] = '0;
      snap();
      exp_mem[9] = 64'h0123456789ABCDEF;
      run_dump("wr_before", 31, 100, 11, 5'd9, 64'h0123456789ABCDEF, 48);
      preload();
      snap();
      // start held high across a whole dump
      begin
         int  early_done = 0, busy_low = 0;
         outReady = 1;
         @(posedge clk); #1 start = 1;
         @(posedge clk); #1;
         for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            if (c < 48 && c_dn) early_done++;
            if (c < 48 && !c_bz) busy_low++;
            if (c == 48) chk("hold_done", 128'(c_dn), 128'(1));
            if (c == 49) chk("hold_idle", {126'd0, c_bz, c_dn}, 128'd0);
            if (c == 50) chk("hold_refetch", {122'd0, c_bz, c_rb}, {122'd0, 1'b1, 5'd1});
            @(posedge clk); #1;
         end
         start = 0;
         chk("hold_single", 128'(early_done + busy_low), 128'd0);
         early_done = 0;
         for (int c = 0; c < 100 && early_done == 0; c++) begin
            @(negedge clk);
            if (c_dn) early_done = 1;
         end
         chk("hold_second_done", 128'(early_done), 128'(1));
      end
      // asynchronous reset during SEND_B of pair 8/9
      begin
         logic found = 0;
         int   dn = 0;
         outReady = 1;
         pulse_start();
         for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (c_ov && c_oa == 5'd9) found = 1;
         end
         chk("reach_addr9", 128'(found), 128'(1));
         #2 reset = 0;
         #1 chk("async_reset", {c_od, 27'd0, c_oa, c_ra, c_rb, c_ov, c_bz, c_dn}, 128'd0);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (c_dn || c_bz || c_ov) dn++;
         end
         @(posedge clk); #1 reset = 1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (c_dn || c_bz || c_ov) dn++;
         end
         chk("reset_quiet", 128'(dn), 128'd0);
         run_dump("after_reset", 31, 100, -1, 5'd0, 64'd0, 48);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter: LAST_ADDR, default 31, highest register dumped (inclusive); odd values 1..31 only.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a dump of registers 0..LAST_ADDR.
REQ-005 SHALL have port: rdAddrA  output  5  register file read address, port A.
REQ-006 SHALL have port: rdAddrB  output  5  register file read address, port B.
REQ-007 SHALL have port: rdDataA  input  64  register file read data, port A (combinational from rdAddrA).
REQ-008 SHALL have port: rdDataB  input  64  register file read data, port B (combinational from rdAddrB).
REQ-009 SHALL have port: outData  output  64  streamed register value.
REQ-010 SHALL have port: outAddr  output  5  register number of outData.
REQ-011 SHALL have port: outValid  output  1  outData/outAddr valid.
REQ-012 SHALL have port: outReady  input  1  sink accepts word; transfer = outValid & outReady at rising edge.
REQ-013 SHALL have port: busy  output  1  dump in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse after last word transferred.

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND_A, SEND_B, DONE, plus a 5-bit pair pointer ptr (always even).
REQ-016 IDLE: start=1 at an edge -> ptr=0, go FETCH; start ignored in all other states.
REQ-017 FETCH (exactly one cycle): rdAddrA=ptr, rdAddrB=ptr+1; at the ending edge bufA<=rdDataA, bufB<=rdDataB; go SEND_A.
REQ-018 rdAddrA and rdAddrB SHALL be 0 in every state other than FETCH.
REQ-019 SEND_A: outValid=1, outData=bufA, outAddr=ptr; on transfer go SEND_B.
REQ-020 SEND_B: outValid=1, outData=bufB, outAddr=ptr+1; on transfer: if ptr+1==LAST_ADDR go DONE, else ptr<=ptr+2, go FETCH.
REQ-021 outValid SHALL be 0 in IDLE, FETCH, DONE; outData/outAddr SHALL be 0 when outValid=0.
REQ-022 While outValid=1 and outReady=0, outData and outAddr SHALL stay constant; outValid SHALL NOT drop before transfer.
REQ-023 DONE (one cycle): done=1, then IDLE; done=0 in all other states.
REQ-024 busy SHALL be 1 in FETCH, SEND_A, SEND_B; 0 in IDLE and DONE.
REQ-025 Latency: start sampled at edge N -> FETCH in cycle N..N+1 -> outValid=1 after edge N+1 (first word register 0).
REQ-026 Throughput with outReady held 1: 3 cycles per pair; full 32-register dump = 48 busy cycles, done at cycle 49 after start edge.
REQ-027 Words SHALL be emitted in strictly ascending outAddr order 0..LAST_ADDR, each exactly once, no gaps.
REQ-028 Each pair SHALL be sampled only in its own FETCH cycle; regfile writes after that cycle are not reflected (no whole-file snapshot).
REQ-029 outReady toggling in IDLE/FETCH/DONE SHALL have no effect.

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) force IDLE, ptr=0, bufA=bufB=0, all outputs 0.
REQ-031 Reset asserted mid-dump SHALL abort it with no done pulse; the next start after reset release SHALL restart from register 0.
REQ-032 Outputs SHALL remain at reset values until the first start after reset deasserts.

Verification
REQ-033 Regfile model preloaded r0=FFFFFFFFFFFFFFFF, r8=AAAAAAAAAAAAAAAA, r15=CCCCCCCCCCCCCCCC, r31=F0F0F0F0F0F0F0F0, others=0; start pulse, outReady=1 -> 32 transfers addr 0..31 with matching data, busy 48 cycles, single done pulse.
REQ-034 Backpressure: outReady random 30% duty -> same 32-word sequence; outData/outAddr constant during every stall; no word dropped or repeated.
REQ-035 Start held high continuously through dump -> exactly one dump, then a second dump begins the cycle after DONE returns to IDLE.
REQ-036 Reset asserted during SEND_B of pair 8/9 -> outValid, busy, rdAddrA/B drop to 0 immediately; no done; new start -> first word addr 0.
REQ-037 LAST_ADDR=7 -> exactly 8 words, addr 0..7, busy 12 cycles with outReady=1, then done.
REQ-038 Write r9=0123456789ABCDEF after pair 8/9 FETCH -> streamed r9 shows old value; same write before that FETCH -> new value streamed.
